// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
//   Shared types for the write-back arbiter: the queued request record, the
//   grant encoding and a register one-hot decode helper.
// ---------------------------------------------------------------------------
package wb_arb_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_A,
    GNT_B
  } grant_e;

  function automatic logic [31:0] reg_onehot(input logic [4:0] r);
    return 32'd1 << r;
  endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//   Small per-requester write FIFO. Besides push/pop/head it exposes every
//   slot in age order (index 0 = head/oldest) with a valid bit, so the parent
//   can build the pending-write vector and forwarding results.
//
//   Optional: WB_FWD_EN adds the o_ent_data view used for forwarding.
//
//   Ports:
//     i_clk, i_rst      clock, synchronous active-high reset
//     i_push, i_req     enqueue request (ignored when full)
//     i_pop             dequeue head (ignored when empty)
//     o_full, o_empty   occupancy flags
//     o_head            oldest entry
//     o_ent_addr/vld    all slots in age order, with valid bits
//     o_ent_data        slot data in age order (WB_FWD_EN only)
// ---------------------------------------------------------------------------
module wb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  wb_req_t          i_req,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output wb_req_t          o_head,
  output logic [4:0]       o_ent_addr [DEPTH],
  output logic [DEPTH-1:0] o_ent_vld
`ifdef WB_FWD_EN
  ,
  output logic [31:0]      o_ent_data [DEPTH]
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  wb_req_t     mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; slot contents are only observed
  // through valid bits derived from the (reset) pointers.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_req;
  end

  assign o_head = mem[rd_ptr[AW-1:0]];

  for (genvar g = 0; g < DEPTH; g++) begin : g_view
    logic [AW-1:0] idx;
    assign idx           = rd_ptr[AW-1:0] + AW'(g);
    assign o_ent_addr[g] = mem[idx].addr;
    assign o_ent_vld[g]  = (count > (AW+1)'(g));
`ifdef WB_FWD_EN
    assign o_ent_data[g] = mem[idx].data;
`endif
  end

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Shares the register-file write port between port A (ALU commit) and
//   port B (LSU load return). Each port feeds a FIFO; one head is drained per
//   cycle. B normally wins, but A is forced through after being denied
//   STARVE_MAX consecutive cycles. o_pend_vec flags every register that still
//   has a queued write so hazard logic can stall on it.
//
//   Optional: define WB_FWD_EN to add two forwarding probes that return the
//   youngest queued data for a register.
//
//   Ports:
//     i_clk, i_rst                 clock, synchronous active-high reset
//     i_a_valid/addr/data, o_a_ready   port A request handshake
//     i_b_valid/addr/data, o_b_ready   port B request handshake
//     o_rd_wren/addr/data          register-file write port
//     o_pend_vec                   bit r set while a queued entry targets xr
//     o_idle                       both FIFOs empty
//     i_fwdN_addr, o_fwdN_hit/data forwarding probes (WB_FWD_EN only)
// ---------------------------------------------------------------------------
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_a_valid,
  input  logic [4:0]  i_a_addr,
  input  logic [31:0] i_a_data,
  output logic        o_a_ready,
  input  logic        i_b_valid,
  input  logic [4:0]  i_b_addr,
  input  logic [31:0] i_b_data,
  output logic        o_b_ready,
  output logic        o_rd_wren,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic [31:0] o_pend_vec,
  output logic        o_idle
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]  i_fwd1_addr,
  input  logic [4:0]  i_fwd2_addr,
  output logic        o_fwd1_hit,
  output logic [31:0] o_fwd1_data,
  output logic        o_fwd2_hit,
  output logic [31:0] o_fwd2_data
`endif
);

  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

  wb_req_t a_req, b_req, a_head, b_head;
  logic    a_full, a_empty, b_full, b_empty;
  logic    a_push, b_push, a_pop, b_pop;
  grant_e  grant;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   pend_raw;

  logic [4:0]            a_ent_addr [FIFO_DEPTH];
  logic [4:0]            b_ent_addr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] a_ent_vld, b_ent_vld;
`ifdef WB_FWD_EN
  logic [31:0]           a_ent_data [FIFO_DEPTH];
  logic [31:0]           b_ent_data [FIFO_DEPTH];
`endif

  assign a_req = '{addr: i_a_addr, data: i_a_data};
  assign b_req = '{addr: i_b_addr, data: i_b_data};

  // Ready is a pure function of stored occupancy: a same-cycle pop never
  // opens space for a push.
  assign o_a_ready = !a_full;
  assign o_b_ready = !b_full;

  // x0 writes complete the handshake but are dropped here.
  assign a_push = i_a_valid && !a_full && (i_a_addr != REG_ZERO);
  assign b_push = i_b_valid && !b_full && (i_b_addr != REG_ZERO);

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (a_push),
    .i_req      (a_req),
    .i_pop      (a_pop),
    .o_full     (a_full),
    .o_empty    (a_empty),
    .o_head     (a_head),
    .o_ent_addr (a_ent_addr),
    .o_ent_vld  (a_ent_vld)
`ifdef WB_FWD_EN
    ,
    .o_ent_data (a_ent_data)
`endif
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (b_push),
    .i_req      (b_req),
    .i_pop      (b_pop),
    .o_full     (b_full),
    .o_empty    (b_empty),
    .o_head     (b_head),
    .o_ent_addr (b_ent_addr),
    .o_ent_vld  (b_ent_vld)
`ifdef WB_FWD_EN
    ,
    .o_ent_data (b_ent_data)
`endif
  );

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = GNT_NONE;
    if (!a_empty && !b_empty) begin
      grant = (starve_cnt == STARVE_LIM) ? GNT_A : GNT_B;
    end else if (!a_empty) begin
      grant = GNT_A;
    end else if (!b_empty) begin
      grant = GNT_B;
    end
  end

  assign a_pop = (grant == GNT_A);
  assign b_pop = (grant == GNT_B);

  // Counts consecutive cycles A waits with data queued; saturating keeps the
  // forced grant asserted until A actually wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (!a_empty && grant != GNT_A) begin
      if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  always_comb begin
    o_rd_wren = 1'b0;
    o_rd_addr = REG_ZERO;
    o_rd_data = '0;
    if (!i_rst) begin
      case (grant)
        GNT_A: begin
          o_rd_wren = 1'b1;
          o_rd_addr = a_head.addr;
          o_rd_data = a_head.data;
        end
        GNT_B: begin
          o_rd_wren = 1'b1;
          o_rd_addr = b_head.addr;
          o_rd_data = b_head.data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pend_raw = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (a_ent_vld[i]) pend_raw |= reg_onehot(a_ent_addr[i]);
      if (b_ent_vld[i]) pend_raw |= reg_onehot(b_ent_addr[i]);
    end
  end

  // Outputs read as the reset state while i_rst is held, even though the
  // FIFOs only clear at the edge.
  assign o_pend_vec = i_rst ? '0 : pend_raw;
  assign o_idle     = i_rst || (a_empty && b_empty);

`ifdef WB_FWD_EN
  logic [4:0]  fwd_addr [2];
  logic        fwd_hit  [2];
  logic [31:0] fwd_data [2];

  assign fwd_addr[0] = i_fwd1_addr;
  assign fwd_addr[1] = i_fwd2_addr;

  // Slots are scanned oldest to youngest so the last match is the youngest.
  // Queued A and B never target the same register, so port order is moot.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd_hit[p]  = 1'b0;
      fwd_data[p] = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (a_ent_vld[i] && a_ent_addr[i] == fwd_addr[p]) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = a_ent_data[i];
        end
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (b_ent_vld[i] && b_ent_addr[i] == fwd_addr[p]) begin
          fwd_hit[p]  = 1'b1;
          fwd_data[p] = b_ent_data[i];
        end
      end
      if (i_rst || fwd_addr[p] == REG_ZERO) begin
        fwd_hit[p]  = 1'b0;
        fwd_data[p] = '0;
      end
    end
  end

  assign o_fwd1_hit  = fwd_hit[0];
  assign o_fwd1_data = fwd_data[0];
  assign o_fwd2_hit  = fwd_hit[1];
  assign o_fwd2_data = fwd_data[1];
`endif

endmodule
